// File: rtl/window_gen_3x3.sv
// ---------------------------------------------------------------------------
// window_gen_3x3
//   Turns a raster-order pixel stream into 3x3 windows for a downstream
//   convolution. Windows are emitted only where a full 3x3 neighbourhood
//   exists inside the frame. The block adds no padding and has no
//   backpressure.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    qualifies in_data for one pixel
//   in_data     signed pixel, raster order (row-major, col 0 first)
//   p00..p22    registered 3x3 window, p<row><col>, row 0 oldest, col 2 newest
//   out_valid   one-cycle pulse per emitted window (latency 1 from the pixel)
//   frame_done  pulses with the window of the last pixel of a frame
// ---------------------------------------------------------------------------
module window_gen_3x3 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic signed [DATA_W-1:0] p00,
    output logic signed [DATA_W-1:0] p01,
    output logic signed [DATA_W-1:0] p02,
    output logic signed [DATA_W-1:0] p10,
    output logic signed [DATA_W-1:0] p11,
    output logic signed [DATA_W-1:0] p12,
    output logic signed [DATA_W-1:0] p20,
    output logic signed [DATA_W-1:0] p21,
    output logic signed [DATA_W-1:0] p22,
    output logic                     out_valid,
    output logic                     frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [0:0] {StFill, StRun} state_e;

    state_e state_q, state_d;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // lb_prev holds row r-1, lb_prev2 holds row r-2, both indexed by column.
    logic signed [DATA_W-1:0] lb_prev  [IMG_W];
    logic signed [DATA_W-1:0] lb_prev2 [IMG_W];

    logic signed [DATA_W-1:0] win_q [3][3];
    logic signed [DATA_W-1:0] top_px, mid_px;

    logic last_px;
    logic out_valid_d, frame_done_d;

    assign last_px = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Line-buffer reads are gated so stale rows from an earlier frame (or
    // from before a reset) never enter the window, even transiently.
    assign top_px = (state_q == StRun) ? lb_prev2[col_q] : '0;
    assign mid_px = (row_q != '0)      ? lb_prev[col_q]  : '0;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: if (in_valid && row_q == ROW_W'(1) && col_q == COL_LAST) state_d = StRun;
            StRun:  if (in_valid && last_px) state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_valid_d  = in_valid && (state_q == StRun) && (col_q >= COL_W'(2));
        frame_done_d = out_valid_d && last_px;
    end

    // ---------------- Position counters ----------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            out_valid  <= out_valid_d;
            frame_done <= frame_done_d;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= top_px;
                win_q[1][2] <= mid_px;
                win_q[2][2] <= in_data;
            end
        end
    end

    // Line buffers need no reset; read gating covers stale contents.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_prev2[col_q] <= lb_prev[col_q];
            lb_prev[col_q]  <= in_data;
        end
    end

    assign p00 = win_q[0][0];
    assign p01 = win_q[0][1];
    assign p02 = win_q[0][2];
    assign p10 = win_q[1][0];
    assign p11 = win_q[1][1];
    assign p12 = win_q[1][2];
    assign p20 = win_q[2][0];
    assign p21 = win_q[2][1];
    assign p22 = win_q[2][2];

endmodule

// File: tb/tb_window_gen_3x3.sv
// ---------------------------------------------------------------------------
// tb_window_gen_3x3
//   Self-checking bench for window_gen_3x3 at IMG_W = IMG_H = 4, DATA_W = 8.
//   A frame image array serves as the reference: every accepted pixel is
//   stored at (r,c) and each expected window is read back from that image.
// ---------------------------------------------------------------------------
module tb_window_gen_3x3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic signed [DW-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic                 out_valid, frame_done;
    logic signed [DW-1:0] p [9];

    always #5 clk = ~clk;

    window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .p00        (p00),
        .p01        (p01),
        .p02        (p02),
        .p10        (p10),
        .p11        (p11),
        .p12        (p12),
        .p20        (p20),
        .p21        (p21),
        .p22        (p22),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    always_comb begin
        p[0] = p00; p[1] = p01; p[2] = p02;
        p[3] = p10; p[4] = p11; p[5] = p12;
        p[6] = p20; p[7] = p21; p[8] = p22;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int  img [H][W];
    int  mr = 0, mc = 0;
    int  last_win [9];
    bit  hold_known = 1'b0;
    int  win_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name, input int exp_w[9]);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s p[%0d]", name, k), int'(p[k]), exp_w[k]);
        end
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        for (int k = 0; k < 9; k++) last_win[k] = 0;
        hold_known = 1'b1;
    endtask

    // One clock: drive inputs, let the edge happen, then check against the model.
    task automatic step(input bit v, input int d);
        bit ev;
        bit efd;
        int ew [9];
        in_valid = v;
        in_data  = DW'(d);
        @(posedge clk);
        #1;
        ev  = 1'b0;
        efd = 1'b0;
        for (int k = 0; k < 9; k++) ew[k] = 0;
        if (v) begin
            img[mr][mc] = d;
            if (mr >= 2 && mc >= 2) begin
                ev = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[i*3+j] = img[mr-2+i][mc-2+j];
                efd = (mr == H-1) && (mc == W-1);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr + 1) % H;
            end
        end
        chk("out_valid", int'(out_valid), int'(ev));
        chk("frame_done", int'(frame_done), int'(efd));
        if (ev) begin
            chk_win("window", ew);
            last_win   = ew;
            hold_known = 1'b1;
            win_count++;
        end else if (v) begin
            hold_known = 1'b0;
        end else if (hold_known) begin
            chk_win("hold", last_win);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst frame_done", int'(frame_done), 0);
        for (int k = 0; k < 9; k++) chk($sformatf("rst p[%0d]", k), int'(p[k]), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic run_frame(input int base, input bit toggle, input bit do_first,
                             input int first_w[9]);
        bit prev_ov = 1'b0;
        bit first_seen = 1'b0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 4*r + c + base);
                if (do_first && !first_seen && out_valid) begin
                    chk_win("first window", first_w);
                    first_seen = 1'b1;
                end
                if (toggle) begin
                    chk("no back-to-back", int'(out_valid && prev_ov), 0);
                    prev_ov = out_valid;
                    step(1'b0, 0);
                    chk("no back-to-back", int'(out_valid && prev_ov), 0);
                    prev_ov = out_valid;
                end
            end
        end
    endtask

    typedef struct {
        bit v;
        int d;
        bit ov;
        bit fd;
        int p00;
        int p22;
    } vec_t;

    vec_t tbl [16];
    int   w_first [9];
    int   w_none  [9];

    initial begin
        // Extreme values at (0,0) and (2,2); others 4r+c.
        tbl[0]  = '{1'b1,  127, 1'b0, 1'b0,   0,    0};
        tbl[1]  = '{1'b1,    1, 1'b0, 1'b0,   0,    0};
        tbl[2]  = '{1'b1,    2, 1'b0, 1'b0,   0,    0};
        tbl[3]  = '{1'b1,    3, 1'b0, 1'b0,   0,    0};
        tbl[4]  = '{1'b1,    4, 1'b0, 1'b0,   0,    0};
        tbl[5]  = '{1'b1,    5, 1'b0, 1'b0,   0,    0};
        tbl[6]  = '{1'b1,    6, 1'b0, 1'b0,   0,    0};
        tbl[7]  = '{1'b1,    7, 1'b0, 1'b0,   0,    0};
        tbl[8]  = '{1'b1,    8, 1'b0, 1'b0,   0,    0};
        tbl[9]  = '{1'b1,    9, 1'b0, 1'b0,   0,    0};
        tbl[10] = '{1'b1, -128, 1'b1, 1'b0, 127, -128};
        tbl[11] = '{1'b1,   11, 1'b1, 1'b0,   1,   11};
        tbl[12] = '{1'b1,   12, 1'b0, 1'b0,   0,    0};
        tbl[13] = '{1'b1,   13, 1'b0, 1'b0,   0,    0};
        tbl[14] = '{1'b1,   14, 1'b1, 1'b0,   4,   14};
        tbl[15] = '{1'b1,   15, 1'b1, 1'b1,   5,   15};
        for (int k = 0; k < 9; k++) w_none[k] = 0;

        async_reset();
        step(1'b0, 0);

        // Table-driven frame with signed extremes
        win_count = 0;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].d);
            chk("tbl out_valid", int'(out_valid), int'(tbl[i].ov));
            chk("tbl frame_done", int'(frame_done), int'(tbl[i].fd));
            if (tbl[i].ov) begin
                chk("tbl p00", int'(p00), tbl[i].p00);
                chk("tbl p22", int'(p22), tbl[i].p22);
            end
        end
        chk("tbl windows", win_count, 4);

        // Contiguous frame, 4r+c
        w_first = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        win_count = 0;
        run_frame(0, 1'b0, 1'b1, w_first);
        chk("contig windows", win_count, 4);

        // Same stream with alternating valid
        win_count = 0;
        run_frame(0, 1'b1, 1'b1, w_first);
        chk("toggle windows", win_count, 4);

        // Two frames back to back, second offset by 100
        win_count = 0;
        run_frame(0, 1'b0, 1'b0, w_none);
        w_first = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        run_frame(100, 1'b0, 1'b1, w_first);
        chk("b2b windows", win_count, 8);

        // Partial frame, reset, then a clean frame
        for (int i = 0; i < 8; i++) step(1'b1, 50 + i);
        async_reset();
        win_count = 0;
        w_first = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        run_frame(0, 1'b0, 1'b1, w_first);
        chk("post-reset windows", win_count, 4);

        // Random data with random gaps
        win_count = 0;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < W*H; i++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) step(1'b0, 0);
                step(1'b1, int'($urandom_range(0, 255)) - 128);
            end
        end
        chk("random windows", win_count, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_W SHALL default to 8 and set the pixel width (signed two's complement).
REQ-003 Parameter IMG_W SHALL default to 28 and set the pixels per row (minimum 3).
REQ-004 Parameter IMG_H SHALL default to 28 and set the rows per frame (minimum 3).
REQ-005 Port clk SHALL be an input, 1 bit wide, and is the sole clock, rising edge.
REQ-006 Port rst SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-007 Port in_valid SHALL be an input, 1 bit wide, and qualifies in_data for one pixel.
REQ-008 Port in_data SHALL be an input, DATA_W bits wide, signed, carrying one pixel in raster order (row-major, col 0 first).
REQ-009 Ports p00, p01, p02, p10, p11, p12, p20, p21, p22 SHALL be registered outputs, DATA_W bits wide, signed, carrying the 3x3 window (p<row><col>, with row 0 oldest).
REQ-010 Port out_valid SHALL be a registered output, 1 bit wide, high for exactly one cycle per emitted window.
REQ-011 Port frame_done SHALL be a registered output, 1 bit wide, pulsing high together with the last window of a frame.

Function
REQ-012 The block SHALL have no backpressure input; the downstream 3x3 convolution consumes every window whose out_valid is high.
REQ-013 The block SHALL maintain counters col (0..IMG_W-1) and row (0..IMG_H-1) that advance only on in_valid cycles; col wraps to 0 and increments row; row wraps to 0 after pixel (IMG_H-1, IMG_W-1).
REQ-014 The block SHALL hold two line buffers of IMG_W entries each, storing rows r-1 and r-2, written and read at index col on every in_valid.
REQ-015 The block SHALL hold a 3x3 window register that shifts left on every in_valid, with column 2 loaded from {linebuf r-2, linebuf r-1, in_data}.
REQ-016 The state machine SHALL have two states: FILL (row < 2) and RUN (row >= 2); FILL->RUN on the in_valid that starts row 2; RUN->FILL on the in_valid of the last pixel of the frame.
REQ-017 For an accepted pixel (r,c) with r>=2 and c>=2, the block SHALL assert out_valid the following cycle, with p22 = pixel (r,c) and p00 = pixel (r-2,c-2); this is latency 1.
REQ-018 The block SHALL NOT assert out_valid for c<2, so no window straddles a row boundary (valid-only, no padding); each frame emits exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-019 When in_valid is low, out_valid SHALL be 0, all p outputs SHALL hold their values, and the counters SHALL hold.
REQ-020 Gaps in in_valid of any length, including mid-row, SHALL NOT alter window content or count.
REQ-021 frame_done SHALL be 1 only in the cycle carrying the window for pixel (IMG_H-1, IMG_W-1).
REQ-022 Back-to-back frames SHALL need no idle cycle; a new frame's first window SHALL contain no data from the previous frame (gated by row<2).
REQ-023 Data SHALL pass unmodified, with no arithmetic, sign extension or rounding.

Reset
REQ-024 While rst=0, the block SHALL asynchronously clear out_valid, frame_done, p00..p22, col and row to 0 and set the state to FILL.
REQ-025 Line buffer contents SHALL NOT require reset; the FILL gating guarantees stale data is never emitted.
REQ-026 A reset mid-frame SHALL discard the partial frame; the next accepted pixel is (0,0) of a new frame.

Verification (IMG_W=4, IMG_H=4, pixel value = 4r+c)
REQ-027 Stream 16 contiguous pixels -> exactly 4 windows; the first, the cycle after pixel 10, has p00..p22 = 0,1,2,4,5,6,8,9,10; the last has p22=15 with frame_done=1.
REQ-028 Same stream with in_valid toggled 1,0,1,0 -> the same 4 windows in order, out_valid never high on consecutive cycles, and p values held between windows.
REQ-029 Two frames back-to-back, with frame 2 value = 4r+c+100 -> frame 2's first window is 100,101,102,104,105,106,108,109,110, and 8 windows in total.
REQ-030 Reset asserted after pixel 7, then a full frame -> no out_valid before the new frame's pixel 10, and 4 correct windows.
REQ-031 Pixels -128 and 127 (DATA_W=8) at positions (2,2) and (0,0) -> p22=-128 and p00=127 in the first window, bit-exact.
REQ-032 Reset asserted asynchronously between clock edges -> all outputs read 0 before the next rising edge.
